hilo_unit: RTL and testbench

- Sequential HI/LO control stage directly downstream of the combinational signed/unsigned multiply and divide units in the 54-instruction CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the decode/execute stage and latches the operands that drive the arithmetic units.
- Models a fixed multi-cycle latency with a counter, then commits the products, quotients and remainders into the architectural HI/LO registers.
- Raises busy/stall so the pipeline holds while a result is pending.

---
 rtl/hilo_unit_if.sv | 34 +++
 rtl/hilo_unit.sv | 105 ++++++++++
 tb/tb_hilo_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - command, operand and HI/LO result bundle for hilo_unit
interface hilo_unit_if;
  logic [2:0]  op;
  logic        op_valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_rd;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [63:0] mult_z;
  logic [63:0] multu_z;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] divu_q;
  logic [31:0] divu_r;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;

  modport master (
    output op, op_valid, rs_data, rt_data, hilo_rd,
    output mult_z, multu_z, div_q, div_r, divu_q, divu_r,
    input  md_a, md_b, hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  op, op_valid, rs_data, rt_data, hilo_rd,
    input  mult_z, multu_z, div_q, div_r, divu_q, divu_r,
    output md_a, md_b, hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO control stage with fixed-latency multiply/divide commit
module hilo_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_unit_if.slave bus
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [2:0]  kind;
  logic [31:0] md_a, md_b, hi, lo;
  logic        done, div_zero;
  logic        accept, commit, is_arith, kind_div;

  assign is_arith = bus.op_valid && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign kind_div = (kind == OP_DIV) || (kind == OP_DIVU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (is_arith) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == 6'd0) begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_a     <= '0;
      md_b     <= '0;
      kind     <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= commit;
      div_zero <= commit && kind_div && (md_b == 32'd0);
      if (accept) begin
        md_a <= bus.rs_data;
        md_b <= bus.rt_data;
        kind <= bus.op;
        cnt  <= ((bus.op == OP_MULT) || (bus.op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
      end else if (state == BUSY && cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end
      if (commit) begin
        case (kind)
          OP_MULT:  {hi, lo} <= bus.mult_z;
          OP_MULTU: {hi, lo} <= bus.multu_z;
          OP_DIV:   if (md_b != 32'd0) begin
            lo <= bus.div_q;
            hi <= bus.div_r;
          end
          OP_DIVU:  if (md_b != 32'd0) begin
            lo <= bus.divu_q;
            hi <= bus.divu_r;
          end
          default: ;
        endcase
      end else if (state == IDLE && bus.op_valid) begin
        // moves share the IDLE path with accept but never enter BUSY
        if (bus.op == OP_MTHI) hi <= bus.rs_data;
        if (bus.op == OP_MTLO) lo <= bus.rs_data;
      end
    end
  end

  assign bus.md_a     = md_a;
  assign bus.md_b     = md_b;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.busy     = (state == BUSY);
  assign bus.stall    = (state == BUSY) && (bus.op_valid || bus.hilo_rd);
  assign bus.done     = done;
  assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hilo_unit_if u0 ();
  hilo_unit_if u1 ();

  hilo_unit #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut  (.clk(clk), .rst(rst), .bus(u0.slave));
  hilo_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1))  dut1 (.clk(clk), .rst(rst), .bus(u1.slave));

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b, input bit rem);
    if (b == 32'd0) return 32'd0;
    return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  function automatic logic [31:0] udiv(input logic [31:0] a, input logic [31:0] b, input bit rem);
    if (b == 32'd0) return 32'd0;
    return rem ? (a % b) : (a / b);
  endfunction

  // combinational multiply/divide units driven by each DUT's latched operands
  assign u0.mult_z  = smul(u0.md_a, u0.md_b);
  assign u0.multu_z = {32'd0, u0.md_a} * {32'd0, u0.md_b};
  assign u0.div_q   = sdiv(u0.md_a, u0.md_b, 1'b0);
  assign u0.div_r   = sdiv(u0.md_a, u0.md_b, 1'b1);
  assign u0.divu_q  = udiv(u0.md_a, u0.md_b, 1'b0);
  assign u0.divu_r  = udiv(u0.md_a, u0.md_b, 1'b1);
  assign u1.mult_z  = smul(u1.md_a, u1.md_b);
  assign u1.multu_z = {32'd0, u1.md_a} * {32'd0, u1.md_b};
  assign u1.div_q   = sdiv(u1.md_a, u1.md_b, 1'b0);
  assign u1.div_r   = sdiv(u1.md_a, u1.md_b, 1'b1);
  assign u1.divu_q  = udiv(u1.md_a, u1.md_b, 1'b0);
  assign u1.divu_r  = udiv(u1.md_a, u1.md_b, 1'b1);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    u0.op = op; u0.op_valid = 1'b1; u0.rs_data = rs; u0.rt_data = rt;
    step();
    u0.op = 3'd0; u0.op_valid = 1'b0;
  endtask

  // returns the number of edges from accept until done is seen
  task automatic wait_done(input int max, input bit chk_stall, output int n);
    n = 0;
    forever begin
      step();
      n++;
      if (u0.done) break;
      check("busy_in_flight", 64'(u0.busy), 64'd1);
      if (chk_stall) check("stall_in_flight", 64'(u0.stall), 64'd1);
      if (n >= max) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ndone;
    u0.op = 3'd0; u0.op_valid = 1'b0; u0.rs_data = '0; u0.rt_data = '0; u0.hilo_rd = 1'b0;
    u1.op = 3'd0; u1.op_valid = 1'b0; u1.rs_data = '0; u1.rt_data = '0; u1.hilo_rd = 1'b0;
    step(); step();
    check("rst_hi", 64'(u0.hi), 64'd0);
    check("rst_lo", 64'(u0.lo), 64'd0);
    check("rst_md_a", 64'(u0.md_a), 64'd0);
    check("rst_busy", 64'(u0.busy), 64'd0);
    check("rst_done", 64'(u0.done), 64'd0);
    check("rst_div_zero", 64'(u0.div_zero), 64'd0);
    rst = 1'b0;
    step();

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy", 64'(u0.busy), 64'd1);
    check("mult_md_a", 64'(u0.md_a), 64'hFFFF_FFFE);
    wait_done(10, 1'b0, n);
    check("mult_latency", 64'(n), 64'd4);
    check("mult_hilo", {u0.hi, u0.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_busy_off", 64'(u0.busy), 64'd0);
    step();
    check("mult_done_once", 64'(u0.done), 64'd0);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done(10, 1'b0, n);
    check("multu_latency", 64'(n), 64'd4);
    check("multu_hilo", {u0.hi, u0.lo}, 64'h0000_0001_FFFF_FFFE);
    step();

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(40, 1'b0, n);
    check("div_latency", 64'(n), 64'd32);
    check("div_hilo", {u0.hi, u0.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_no_zero", 64'(u0.div_zero), 64'd0);
    step();

    issue(3'd5, 32'h11, 32'd0);
    check("mthi_hi", 64'(u0.hi), 64'h11);
    check("mthi_no_busy", 64'(u0.busy), 64'd0);
    issue(3'd6, 32'h22, 32'd0);
    check("mtlo_lo", 64'(u0.lo), 64'h22);
    check("mtlo_no_done", 64'(u0.done), 64'd0);
    issue(3'd4, 32'd1234, 32'd0);
    wait_done(40, 1'b0, n);
    check("divz_latency", 64'(n), 64'd32);
    check("divz_flag", 64'(u0.div_zero), 64'd1);
    check("divz_hilo", {u0.hi, u0.lo}, 64'h0000_0011_0000_0022);
    step();
    check("divz_flag_once", 64'(u0.div_zero), 64'd0);

    issue(3'd1, 32'd3, 32'd4);
    u0.op = 3'd6; u0.op_valid = 1'b1; u0.rs_data = 32'h55; u0.hilo_rd = 1'b1;
    check("stall_first", 64'(u0.stall), 64'd1);
    check("stall_lo_held", 64'(u0.lo), 64'h22);
    wait_done(10, 1'b1, n);
    check("stall_latency", 64'(n), 64'd4);
    check("stall_commit_lo", 64'(u0.lo), 64'd12);
    check("stall_commit_off", 64'(u0.stall), 64'd0);
    step();
    u0.op = 3'd0; u0.op_valid = 1'b0; u0.hilo_rd = 1'b0;
    check("stall_mtlo_lo", 64'(u0.lo), 64'h55);
    check("stall_mtlo_hi", 64'(u0.hi), 64'd0);
    check("stall_mtlo_no_busy", 64'(u0.busy), 64'd0);

    issue(3'd3, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hi", 64'(u0.hi), 64'd0);
    check("arst_lo", 64'(u0.lo), 64'd0);
    check("arst_busy", 64'(u0.busy), 64'd0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (u0.done) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    check("arst_hilo_after", {u0.hi, u0.lo}, 64'd0);

    u1.op = 3'd1; u1.op_valid = 1'b1; u1.rs_data = 32'd5; u1.rt_data = 32'd6;
    step();
    u1.op = 3'd0; u1.op_valid = 1'b0;
    check("p1_busy", 64'(u1.busy), 64'd1);
    check("p1_done_early", 64'(u1.done), 64'd0);
    step();
    check("p1_done", 64'(u1.done), 64'd1);
    check("p1_busy_off", 64'(u1.busy), 64'd0);
    check("p1_lo", 64'(u1.lo), 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
